// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and limits for the Ibex bus memory responder.
package ibex_mem_resp_pkg;

  // One response beat as it travels down the latency pipe.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  // Deepest grant-to-rvalid delay the pipe is built for.
  localparam int unsigned MaxLatency = 4;

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth delay line carrying a valid flag and a response beat.
// Every stage, including the payload, is cleared on reset, so the
// responder shows rdata = 0 and err = 0 whenever no response is present.
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid,
  input  mem_resp_t in_resp,
  output logic      out_valid,
  output mem_resp_t out_resp
);

  logic [Latency-1:0] valid_r;
  mem_resp_t          resp_r [Latency];

  // Shift the valid flags and payloads one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= '0;
      for (int i = 0; i < Latency; i++) begin
        resp_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      resp_r[0]  <= in_resp;
      for (int i = 1; i < Latency; i++) begin
        valid_r[i] <= valid_r[i-1];
        resp_r[i]  <= resp_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[Latency-1];
  assign out_resp  = resp_r[Latency-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word-addressed
// store, fixed response latency, bounded outstanding count, range errors.
module ibex_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned MemDepth       = 1024,
  parameter logic [31:0] AddrBase       = 32'h0000_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned IdxW      = $clog2(MemDepth);
  localparam int unsigned PipeDepth = (ReadLatency > MaxLatency) ? MaxLatency : ReadLatency;
  localparam logic [32:0] AddrLimit = {1'b0, AddrBase} + (33'(MemDepth) * 33'd4);
  localparam logic [2:0]  MaxOut    = 3'(MaxOutstanding);

  logic [31:0]     mem_r [MemDepth];
  logic [2:0]      outstanding_r;
  logic            grant_s;
  logic            in_range_s;
  logic            wr_en_s;
  logic [IdxW-1:0] idx_s;
  mem_resp_t       pipe_in_s;
  mem_resp_t       pipe_out_s;
  logic            pipe_out_valid_s;

  // Grant is combinational so a request can be accepted in the cycle it appears.
  assign grant_s = req_i & ~stall_i & ~rst_i & (outstanding_r < MaxOut);

  // 33-bit compare so the upper limit cannot wrap when the window ends at 4 GiB.
  assign in_range_s = ({1'b0, addr_i} >= {1'b0, AddrBase}) && ({1'b0, addr_i} < AddrLimit);

  // AddrBase is aligned to the window size, so the word index is just the low address bits.
  assign idx_s   = addr_i[IdxW+1:2];
  assign wr_en_s = grant_s & we_i & in_range_s;

  // Build the response beat for the request being granted; idle cycles push zeros.
  always_comb begin
    pipe_in_s = '0;
    if (grant_s && !in_range_s) begin
      pipe_in_s.err = 1'b1;
    end else if (grant_s && !we_i) begin
      pipe_in_s.rdata = mem_r[idx_s];
    end else begin
      pipe_in_s = '0;
    end
  end

  // Byte-masked write into the store at the grant edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_r[idx_s][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Track granted-but-unanswered requests; grant and response together cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_r <= 3'd0;
    end else begin
      case ({grant_s, pipe_out_valid_s})
        2'b10:   outstanding_r <= outstanding_r + 3'd1;
        2'b01:   outstanding_r <= outstanding_r - 3'd1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  ibex_mem_resp_pipe #(
    .Latency(PipeDepth)
  ) u_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (grant_s),
    .in_resp  (pipe_in_s),
    .out_valid(pipe_out_valid_s),
    .out_resp (pipe_out_s)
  );

  assign gnt_o         = grant_s;
  assign rvalid_o      = pipe_out_valid_s;
  assign rdata_o       = pipe_out_s.rdata;
  assign err_o         = pipe_out_s.err;
  assign outstanding_o = outstanding_r;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder: three instances with different
// latency / outstanding / base settings, a vector table plus corner sequences.
module tb_ibex_mem_responder;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst    [3];
  logic        req    [3];
  logic        gnt    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];
  logic        stall  [3];
  logic [2:0]  outst  [3];

  int n_cmp = 0;
  int n_bad = 0;
  int lat_tab [3] = '{1, 2, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: latency 1, two outstanding, base 0
  ibex_mem_responder #(.MemDepth(16), .AddrBase(32'h0000_0000), .ReadLatency(1), .MaxOutstanding(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .stall_i(stall[0]), .outstanding_o(outst[0]));

  // u1: latency 2, one outstanding
  ibex_mem_responder #(.MemDepth(16), .AddrBase(32'h0000_0000), .ReadLatency(2), .MaxOutstanding(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .stall_i(stall[1]), .outstanding_o(outst[1]));

  // u2: latency 3, base 0x100 (window 0x100..0x13F)
  ibex_mem_responder #(.MemDepth(16), .AddrBase(32'h0000_0100), .ReadLatency(3), .MaxOutstanding(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
    .stall_i(stall[2]), .outstanding_o(outst[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete transfer on instance i with bounded waits for grant and response.
  task automatic txn(input int i, input vec_t v, input string nm);
    int waited;
    int lat_seen;
    @(negedge clk);
    req[i] = 1'b1; we[i] = v.we; be[i] = v.be; addr[i] = v.addr; wdata[i] = v.wdata;
    #1;
    waited = 0;
    while (!gnt[i] && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!gnt[i]) begin
      chk({nm, " gnt_timeout"}, 32'd0, 32'd1);
      req[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
    lat_seen = 1;
    while (!rvalid[i] && lat_seen < 10) begin
      @(posedge clk); #1;
      lat_seen++;
    end
    chk({nm, " latency"}, 32'(lat_seen), 32'(lat_tab[i]));
    chk({nm, " rdata"}, rdata[i], v.exp_rdata);
    chk({nm, " err"}, {31'd0, err[i]}, {31'd0, v.exp_err});
  endtask

  vec_t tab [12];
  logic exp_gnt [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic exp_rv  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [2:0] exp_out [6] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1};

  initial begin
    int rv_after_rst;
    vec_t v;

    //                 we    be       addr          wdata          exp_rdata      err
    tab[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    tab[1]  = '{1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    tab[2]  = '{1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b0};
    tab[3]  = '{1'b1, 4'h5, 32'h20, 32'h11223344, 32'h0,        1'b0};
    tab[4]  = '{1'b0, 4'hF, 32'h20, 32'h0,        32'hFF22FF44, 1'b0};
    tab[5]  = '{1'b1, 4'h0, 32'h22, 32'h55555555, 32'h0,        1'b0};
    tab[6]  = '{1'b0, 4'hF, 32'h23, 32'h0,        32'hFF22FF44, 1'b0};
    tab[7]  = '{1'b1, 4'hF, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b0};
    tab[8]  = '{1'b0, 4'hF, 32'h40, 32'h0,        32'h0,        1'b1};
    tab[9]  = '{1'b1, 4'hF, 32'h40, 32'h12345678, 32'h0,        1'b1};
    tab[10] = '{1'b0, 4'hF, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
    tab[11] = '{1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0;
      addr[i] = 32'h0; wdata[i] = 32'h0; stall[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset rvalid u%0d", i), {31'd0, rvalid[i]}, 32'd0);
      chk($sformatf("reset rdata u%0d", i), rdata[i], 32'd0);
      chk($sformatf("reset outstanding u%0d", i), {29'd0, outst[i]}, 32'd0);
    end
    req[0] = 1'b1; #1;
    chk("gnt blocked in reset", {31'd0, gnt[0]}, 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Vector table on u0
    for (int t = 0; t < 12; t++) begin
      txn(0, tab[t], $sformatf("vec%0d", t));
    end

    // Stall for three cycles while a response is pending on u0
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; #1;
    chk("stall pre gnt", {31'd0, gnt[0]}, 32'd1);
    @(posedge clk); #1;
    chk("stall outstanding", {29'd0, outst[0]}, 32'd1);
    @(negedge clk);
    stall[0] = 1'b1; addr[0] = 32'h3C; #1;
    chk("stall gnt c1", {31'd0, gnt[0]}, 32'd0);
    chk("stall pending rvalid", {31'd0, rvalid[0]}, 32'd1);
    chk("stall pending rdata", rdata[0], 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("stall gnt c2", {31'd0, gnt[0]}, 32'd0);
    @(negedge clk); #1;
    chk("stall gnt c3", {31'd0, gnt[0]}, 32'd0);
    @(negedge clk);
    stall[0] = 1'b0; #1;
    chk("stall gnt c4", {31'd0, gnt[0]}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("stall post rvalid", {31'd0, rvalid[0]}, 32'd1);
    chk("stall post rdata", rdata[0], 32'hCAFEF00D);

    // Held request on u1 (latency 2, one outstanding)
    v = '{1'b1, 4'hF, 32'h8, 32'h13579BDF, 32'h0, 1'b0};
    txn(1, v, "u1 preload");
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8;
      #1;
      chk($sformatf("hold gnt c%0d", c), {31'd0, gnt[1]}, {31'd0, exp_gnt[c]});
      chk($sformatf("hold rvalid c%0d", c), {31'd0, rvalid[1]}, {31'd0, exp_rv[c]});
      chk($sformatf("hold outstanding c%0d", c), {29'd0, outst[1]}, {29'd0, exp_out[c]});
      if (exp_rv[c]) chk($sformatf("hold rdata c%0d", c), rdata[1], 32'h13579BDF);
    end
    @(negedge clk);
    req[1] = 1'b0; #1;
    chk("hold drained", {29'd0, outst[1]}, 32'd0);

    // u2: base offset bounds, then reset with a read in flight
    v = '{1'b1, 4'hF, 32'h104, 32'h0BADCAFE, 32'h0, 1'b0};
    txn(2, v, "u2 write");
    v = '{1'b0, 4'hF, 32'hFC, 32'h0, 32'h0, 1'b1};
    txn(2, v, "u2 below base");
    v = '{1'b0, 4'hF, 32'h140, 32'h0, 32'h0, 1'b1};
    txn(2, v, "u2 above top");
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h104; #1;
    chk("rst read gnt", {31'd0, gnt[2]}, 32'd1);
    @(posedge clk); #1;
    chk("rst inflight outstanding", {29'd0, outst[2]}, 32'd1);
    @(negedge clk);
    rst[2] = 1'b1; #1;
    chk("rst blocks gnt", {31'd0, gnt[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b0; req[2] = 1'b0;
    rv_after_rst = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rvalid[2]) rv_after_rst++;
      @(negedge clk);
    end
    chk("rst no rvalid", 32'(rv_after_rst), 32'd0);
    chk("rst outstanding", {29'd0, outst[2]}, 32'd0);
    v = '{1'b0, 4'hF, 32'h104, 32'h0, 32'h0BADCAFE, 1'b0};
    txn(2, v, "u2 after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
